// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: opcode encodings, field widths,
// FSM state encoding and the pre-decoded flag bundle.
package alu_issue_stage_pkg;

  localparam int unsigned OPC_W   = 5;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [OPC_W-1:0] OP_ADD = 5'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 5'd1;
  localparam logic [OPC_W-1:0] OP_AND = 5'd2;
  localparam logic [OPC_W-1:0] OP_OR  = 5'd3;
  localparam logic [OPC_W-1:0] OP_SLL = 5'd4;
  localparam logic [OPC_W-1:0] OP_SRA = 5'd5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic direction;
    logic is_shift;
    logic illegal_op;
  } predec_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side handshake plus issued payload towards the shifter/ALU.
interface alu_issue_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 8
);
  import alu_issue_stage_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_operandA;
  logic [WIDTH-1:0]   data_operandB;
  logic [OPC_W-1:0]   ctrl_ALUopcode;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic [TAG_W-1:0]   in_tag;
  logic               ctrl_flush;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_operand;
  logic [WIDTH-1:0]   data_operandB_q;
  logic [SHAMT_W-1:0] ctrl_shiftamt_q;
  logic               direction;
  logic               is_shift;
  logic               illegal_op;
  logic [OPC_W-1:0]   ctrl_ALUopcode_q;
  logic [TAG_W-1:0]   out_tag;
  logic [CNT_W-1:0]   issued_count;

  modport master (
    output in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
           in_tag, ctrl_flush, out_ready,
    input  in_ready, out_valid, data_operand, data_operandB_q, ctrl_shiftamt_q,
           direction, is_shift, illegal_op, ctrl_ALUopcode_q, out_tag, issued_count
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
           in_tag, ctrl_flush, out_ready,
    output in_ready, out_valid, data_operand, data_operandB_q, ctrl_shiftamt_q,
           direction, is_shift, illegal_op, ctrl_ALUopcode_q, out_tag, issued_count
  );

endinterface

// File: rtl/alu_issue_predecode.sv
// Combinational opcode pre-decode: shifter direction, shift flag, illegal flag.
module alu_issue_predecode
  import alu_issue_stage_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output predec_t          flags_c
);

  always_comb begin
    flags_c            = '0;
    flags_c.direction  = opcode[0];
    flags_c.is_shift   = (opcode[OPC_W-1:1] == 4'b0010);
    flags_c.illegal_op = (opcode > OP_SRA);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage: two-entry skid buffer (main + skid) between decode
// and the ALU shift datapath, with opcode pre-decode stored per entry.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  alu_issue_stage_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [OPC_W-1:0]   opcode;
    logic [SHAMT_W-1:0] shamt;
    logic [TAG_W-1:0]   tag;
    predec_t            flags;
  } entry_t;

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, out_valid_q;
  entry_t           main_q, skid_q, in_entry_c;
  predec_t          in_flags_c;
  logic [CNT_W-1:0] issued_q;
  logic             in_fire_c, out_fire_c;
  logic             load_main_in_c, load_main_skid_c, load_skid_c, count_inc_c;

  alu_issue_predecode u_predecode (
    .opcode  (bus.ctrl_ALUopcode),
    .flags_c (in_flags_c)
  );

  always_comb begin
    in_entry_c        = '0;
    in_entry_c.op_a   = bus.data_operandA;
    in_entry_c.op_b   = bus.data_operandB;
    in_entry_c.opcode = bus.ctrl_ALUopcode;
    in_entry_c.shamt  = bus.ctrl_shiftamt;
    in_entry_c.tag    = bus.in_tag;
    in_entry_c.flags  = in_flags_c;
  end

  assign in_fire_c  = bus.in_valid & in_ready_q;
  assign out_fire_c = out_valid_q & bus.out_ready;

  // Next-state and buffer-move decode; flush overrides every transition.
  always_comb begin
    state_d          = state_q;
    load_main_in_c   = 1'b0;
    load_main_skid_c = 1'b0;
    load_skid_c      = 1'b0;
    count_inc_c      = 1'b0;
    if (bus.ctrl_flush) begin
      state_d = ST_EMPTY;
    end else begin
      count_inc_c = out_fire_c;
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_c) begin
            load_main_in_c = 1'b1;
            state_d        = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire_c && out_fire_c) begin
            load_main_in_c = 1'b1;
          end else if (in_fire_c) begin
            load_skid_c = 1'b1;
            state_d     = ST_FULL;
          end else if (out_fire_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire_c) begin
            load_main_skid_c = 1'b1;
            state_d          = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so in_ready never
  // depends combinationally on out_ready.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in_c) begin
        main_q <= in_entry_c;
      end else if (load_main_skid_c) begin
        main_q <= skid_q;
      end
      if (load_skid_c) begin
        skid_q <= in_entry_c;
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      issued_q <= '0;
    end else if (count_inc_c) begin
      issued_q <= issued_q + CNT_W'(1);
    end
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.data_operand     = main_q.op_a;
  assign bus.data_operandB_q  = main_q.op_b;
  assign bus.ctrl_shiftamt_q  = main_q.shamt;
  assign bus.ctrl_ALUopcode_q = main_q.opcode;
  assign bus.out_tag          = main_q.tag;
  assign bus.direction        = main_q.flags.direction;
  assign bus.is_shift         = main_q.flags.is_shift;
  assign bus.illegal_op       = main_q.flags.illegal_op;
  assign bus.issued_count     = issued_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: scoreboard monitor plus scenario tasks.
module tb_alu_issue_stage;

  logic clock;
  logic ctrl_reset_n;

  alu_issue_stage_if #(.WIDTH(32), .TAG_W(4), .CNT_W(8)) bus ();

  alu_issue_stage #(.WIDTH(32), .TAG_W(4), .CNT_W(8)) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .bus          (bus)
  );

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  opc;
    logic [4:0]  sh;
    logic        dir;
    logic        shf;
    logic        ill;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_cnt = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t model(input logic [3:0] tag, input logic [4:0] opc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.opc = opc; e.sh = sh;
    e.dir = (opc == 5'd5) || (opc % 2 == 1);
    e.shf = (opc == 5'd4) || (opc == 5'd5);
    e.ill = (opc >= 5'd6);
    return e;
  endfunction

  // Scoreboard monitor: checks counter and every issued op at the falling edge.
  always @(negedge clock) begin
    exp_t e;
    exp_t act;
    if (!ctrl_reset_n) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      tests++;
      if (bus.issued_count !== exp_cnt) begin
        fails++;
        $display("FAIL issued_count: got %0d, required %0d", bus.issued_count, exp_cnt);
      end
      if (bus.ctrl_flush) begin
        sb.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          exp_cnt++;
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_issue: got tag %0d, required no output", bus.out_tag);
          end else begin
            e = sb.pop_front();
            act.tag = bus.out_tag;          act.a = bus.data_operand;
            act.b = bus.data_operandB_q;    act.opc = bus.ctrl_ALUopcode_q;
            act.sh = bus.ctrl_shiftamt_q;   act.dir = bus.direction;
            act.shf = bus.is_shift;         act.ill = bus.illegal_op;
            if (act !== e) begin
              fails++;
              $display("FAIL issue_payload: got %h, required %h", act, e);
            end
          end
        end
        if (bus.in_valid && bus.in_ready)
          sb.push_back(model(bus.in_tag, bus.ctrl_ALUopcode, bus.data_operandA,
                             bus.data_operandB, bus.ctrl_shiftamt));
      end
    end
  end

  task automatic send(input logic [3:0] tag, input logic [4:0] opc,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    logic ok;
    bus.in_valid = 1'b1; bus.in_tag = tag; bus.ctrl_ALUopcode = opc;
    bus.data_operandA = a; bus.data_operandB = b; bus.ctrl_shiftamt = sh;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      ok = bus.in_ready;
      @(posedge clock); #1;
      if (ok) return;
    end
    tests++; fails++;
    $display("FAIL send_timeout: tag %0d not accepted, required acceptance within 50 cycles", tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0 && !bus.out_valid) return;
      @(posedge clock); #1;
    end
    tests++; fails++;
    $display("FAIL drain_timeout: %0d ops pending, required 0", sb.size());
  endtask

  task automatic test_reset();
    ctrl_reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ctrl_flush = 1'b0;
    bus.in_tag = '0; bus.ctrl_ALUopcode = '0; bus.ctrl_shiftamt = '0;
    bus.data_operandA = '0; bus.data_operandB = '0;
    repeat (3) @(posedge clock);
    #2 ctrl_reset_n = 1'b1;
    @(posedge clock); #1;
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.direction, bus.is_shift, bus.illegal_op} !== 5'b01000) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 01000",
               {bus.out_valid, bus.in_ready, bus.direction, bus.is_shift, bus.illegal_op});
    end
    tests++;
    if ({bus.data_operand, bus.out_tag, bus.issued_count} !== 44'd0) begin
      fails++;
      $display("FAIL reset_payload: got %h, required 0", {bus.data_operand, bus.out_tag, bus.issued_count});
    end
  endtask

  task automatic test_first_op();
    bus.out_ready = 1'b1;
    send(4'd1, 5'b00101, 32'h8000_0000, 32'h1234_5678, 5'd4);
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.out_valid, bus.direction, bus.is_shift, bus.illegal_op} !== 4'b1110) begin
      fails++;
      $display("FAIL first_flags: got %b, required 1110",
               {bus.out_valid, bus.direction, bus.is_shift, bus.illegal_op});
    end
    tests++;
    if (bus.data_operand !== 32'h8000_0000 || bus.ctrl_shiftamt_q !== 5'd4) begin
      fails++;
      $display("FAIL first_payload: got A=%h sh=%0d, required A=80000000 sh=4",
               bus.data_operand, bus.ctrl_shiftamt_q);
    end
    @(posedge clock); #1;
    tests++;
    if (bus.issued_count !== 8'd1) begin
      fails++;
      $display("FAIL first_count: got %0d, required 1", bus.issued_count);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (bus.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_in_ready: op %0d got %b, required 1", i, bus.in_ready);
      end
      send(4'(i), 5'(i % 6), $urandom, $urandom, 5'($urandom_range(0, 31)));
    end
    bus.in_valid = 1'b0;
    drain();
    tests++;
    if (bus.issued_count !== 8'd11) begin
      fails++;
      $display("FAIL b2b_count: got %0d, required 11", bus.issued_count);
    end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    send(4'd3, 5'd4, 32'h0000_0003, 32'h0, 5'd1);
    send(4'd4, 5'd5, 32'h0000_0004, 32'h0, 5'd2);
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_tag} !== 6'b01_0011) begin
      fails++;
      $display("FAIL stall_full: got rdy=%b vld=%b tag=%0d, required rdy=0 vld=1 tag=3",
               bus.in_ready, bus.out_valid, bus.out_tag);
    end
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_tag} !== 6'b11_0100) begin
      fails++;
      $display("FAIL stall_release: got rdy=%b vld=%b tag=%0d, required rdy=1 vld=1 tag=4",
               bus.in_ready, bus.out_valid, bus.out_tag);
    end
    @(posedge clock); #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.issued_count !== 8'd13) begin
      fails++;
      $display("FAIL stall_drain: got vld=%b cnt=%0d, required vld=0 cnt=13",
               bus.out_valid, bus.issued_count);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    send(4'd5, 5'd0, 32'h55, 32'h66, 5'd0);
    send(4'd6, 5'd1, 32'h77, 32'h88, 5'd0);
    bus.in_tag = 4'd7; bus.ctrl_ALUopcode = 5'd2;
    bus.out_ready = 1'b1; bus.ctrl_flush = 1'b1;
    @(posedge clock); #1;
    bus.ctrl_flush = 1'b0; bus.in_valid = 1'b0;
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01 || bus.issued_count !== 8'd13) begin
      fails++;
      $display("FAIL flush_state: got vld=%b rdy=%b cnt=%0d, required vld=0 rdy=1 cnt=13",
               bus.out_valid, bus.in_ready, bus.issued_count);
    end
    repeat (4) @(posedge clock);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_quiet: got vld=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b0;
    send(4'd8, 5'b00110, 32'hAAAA_0000, 32'h1, 5'd3);
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.illegal_op, bus.is_shift} !== 2'b10) begin
      fails++;
      $display("FAIL illegal_flags: got ill=%b shf=%b, required ill=1 shf=0", bus.illegal_op, bus.is_shift);
    end
    bus.out_ready = 1'b1;
    send(4'd9, 5'b00100, 32'h0000_BBBB, 32'h2, 5'd7);
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.is_shift, bus.direction, bus.illegal_op, bus.out_tag} !== 7'b100_1001) begin
      fails++;
      $display("FAIL sll_flags: got shf=%b dir=%b ill=%b tag=%0d, required shf=1 dir=0 ill=0 tag=9",
               bus.is_shift, bus.direction, bus.illegal_op, bus.out_tag);
    end
    drain();
  endtask

  task automatic test_wrap_and_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 241; i++)
      send(4'(i), 5'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
    bus.in_valid = 1'b0;
    drain();
    tests++;
    if (bus.issued_count !== 8'd0) begin
      fails++;
      $display("FAIL count_wrap: got %0d, required 0", bus.issued_count);
    end
    bus.out_ready = 1'b0;
    send(4'd1, 5'd4, 32'h1, 32'h0, 5'd1);
    send(4'd2, 5'd5, 32'h2, 32'h0, 5'd1);
    bus.in_valid = 1'b0;
    #2 ctrl_reset_n = 1'b0;
    #1;
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01 || bus.issued_count !== 8'd0) begin
      fails++;
      $display("FAIL async_reset: got vld=%b rdy=%b cnt=%0d, required vld=0 rdy=1 cnt=0",
               bus.out_valid, bus.in_ready, bus.issued_count);
    end
    @(posedge clock); #2;
    ctrl_reset_n = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    send(4'd12, 5'd5, 32'hF000_0000, 32'h3, 5'd8);
    bus.in_valid = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_first_op();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_wrap_and_reset();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: got %0d ops, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
